// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and defaults for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter, LSU wins the first tie after reset
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_ifu,
    input  logic req_lsu,
    output logic gnt_ifu,
    output logic gnt_lsu
);

    // 1 means the LSU received the most recent grant
    logic last_lsu_q;

    always_comb begin
        gnt_lsu = en && req_lsu && (!req_ifu || !last_lsu_q);
        gnt_ifu = en && req_ifu && (!req_lsu ||  last_lsu_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_lsu_q <= 1'b0;
        end else if (gnt_lsu || gnt_ifu) begin
            last_lsu_q <= gnt_lsu;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding IFU/LSU arbiter onto one memory port with timeout
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_gnt,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    owner_t      owner_q;
    logic [7:0]  cnt_q;
    logic [31:0] addr_q;
    logic        wen_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic        resp;
    logic [31:0] resp_data;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q == IDLE),
        .req_ifu (ifu_req),
        .req_lsu (lsu_req),
        .gnt_ifu (ifu_gnt),
        .gnt_lsu (lsu_gnt)
    );

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_addr  = 32'h0;
        mem_wen   = 1'b0;
        mem_wdata = 32'h0;
        mem_wmask = 4'h0;
        resp      = 1'b0;
        resp_data = 32'h0;
        bus_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ifu_gnt || lsu_gnt) state_d = ISSUE;
            end
            ISSUE: begin
                mem_req   = 1'b1;
                mem_addr  = addr_q & ~32'h3;
                mem_wen   = wen_q;
                mem_wdata = wdata_q;
                mem_wmask = wmask_q;
                state_d   = WAIT;
            end
            WAIT: begin
                // a real response on the last allowed cycle beats the timeout
                if (mem_rvalid) begin
                    resp      = 1'b1;
                    resp_data = mem_rdata;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    resp      = 1'b1;
                    resp_data = ERR_DATA;
                    bus_err   = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ifu_rvalid = resp && (owner_q == OWN_IFU);
        lsu_rvalid = resp && (owner_q == OWN_LSU);
        ifu_rdata  = ifu_rvalid ? resp_data : 32'h0;
        lsu_rdata  = lsu_rvalid ? resp_data : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IFU;
            cnt_q   <= 8'h0;
            addr_q  <= 32'h0;
            wen_q   <= 1'b0;
            wdata_q <= 32'h0;
            wmask_q <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == WAIT) ? cnt_q + 8'h1 : 8'h0;
            if (lsu_gnt) begin
                owner_q <= OWN_LSU;
                addr_q  <= lsu_addr;
                wen_q   <= lsu_wen;
                wdata_q <= lsu_wdata;
                wmask_q <= lsu_wmask;
            end else if (ifu_gnt) begin
                owner_q <= OWN_IFU;
                addr_q  <= ifu_addr;
                wen_q   <= 1'b0;
                wdata_q <= 32'h0;
                wmask_q <= 4'h0;
            end
        end
    end

endmodule
